// File: rtl/logic_unit_if.sv
// Stream bundle for logic_unit_pipe: producer-side operation stream,
// consumer-side result stream, plus accumulator/counter observation.
interface logic_unit_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             in_acc;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_parity;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] op_count;

    // Driving side: the producer/consumer environment around the block.
    modport master (
        output in_valid, in_a, in_b, in_op, in_acc, acc_clr, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_parity, acc_q, op_count
    );

    // The logic unit itself.
    modport slave (
        input  in_valid, in_a, in_b, in_op, in_acc, acc_clr, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_parity, acc_q, op_count
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with valid/ready on both sides, an optional
// accumulator operand, zero/parity flags and an accepted-transaction counter.
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    logic_unit_if.slave  bus
);
    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_NOT    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XOR    = 3'd5,
        OP_XNOR   = 3'd6,
        OP_PASS_B = 3'd7
    } op_e;

    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_parity;
    logic [WIDTH-1:0] acc_q;
    logic [CNT_W-1:0] op_count;

    logic             in_ready;
    logic             accept;
    logic             transfer;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] res;

    // Single output register: a new operation may enter whenever the
    // current result leaves in the same cycle.
    assign in_ready = !out_valid || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign transfer = out_valid && bus.out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        a_eff = bus.in_a;
        res   = '0;
        if (bus.in_acc) begin
            a_eff = bus.acc_clr ? '0 : acc_q;
        end
        unique case (op_e'(bus.in_op))
            OP_AND:    res = a_eff & bus.in_b;
            OP_OR:     res = a_eff | bus.in_b;
            OP_NOT:    res = ~a_eff;
            OP_NAND:   res = ~(a_eff & bus.in_b);
            OP_NOR:    res = ~(a_eff | bus.in_b);
            OP_XOR:    res = a_eff ^ bus.in_b;
            OP_XNOR:   res = ~(a_eff ^ bus.in_b);
            OP_PASS_B: res = bus.in_b;
            default:   res = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_zero   <= 1'b0;
            out_parity <= 1'b0;
            op_count   <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_data   <= res;
            out_zero   <= (res == '0);
            out_parity <= ^res;
            op_count   <= op_count + 1'b1;
        end else if (transfer) begin
            out_valid  <= 1'b0;
        end
    end

    // The accumulator ignores backpressure: a clear lands even while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (accept && bus.in_acc) begin
            acc_q <= res;
        end else if (bus.acc_clr) begin
            acc_q <= '0;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = out_data;
    assign bus.out_zero   = out_zero;
    assign bus.out_parity = out_parity;
    assign bus.acc_q      = acc_q;
    assign bus.op_count   = op_count;
endmodule
